// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_seq_pkg
//  Description : Shared definitions for the PLL lock sequencer: the FSM state
//                encoding (also used by the debug register map) and the
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // 3-bit state encoding, visible on the debug 'state' port.
    localparam logic [2:0] C_ST_RESET_PLL = 3'd0;
    localparam logic [2:0] C_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] C_ST_STABLE    = 3'd2;
    localparam logic [2:0] C_ST_RELEASE   = 3'd3;
    localparam logic [2:0] C_ST_RUN       = 3'd4;
    localparam logic [2:0] C_ST_FAULT     = 3'd5;

    // Symbolic view of the same encoding for software and debug decoders.
    typedef enum logic [2:0] {
        ST_RESET_PLL = C_ST_RESET_PLL,
        ST_WAIT_LOCK = C_ST_WAIT_LOCK,
        ST_STABLE    = C_ST_STABLE,
        ST_RELEASE   = C_ST_RELEASE,
        ST_RUN       = C_ST_RUN,
        ST_FAULT     = C_ST_FAULT
    } pll_state_e;

    // Width of a counter able to hold 0..max_count with one bit of headroom.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage : pll_seq_pkg
`default_nettype wire

// File: rtl/pll_lock_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_sync
//  Description : WIDTH-bit two-flop synchroniser for the raw PLL lock outputs.
//                'clr' holds both stages at zero while the PLLs are in reset,
//                so a stale lock indication can never leak into a new attempt.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sync #(
    parameter int WIDTH = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync;

    // Two back-to-back capture stages; cleared by reset or while PLLs are held.
    always_ff @(posedge refclk) begin
        if (rst || clr) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule : pll_lock_sync
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_sequencer
//  Description : Bring-up and lock supervisor for NUM_PLLS PLLs. Pulses the
//                PLL reset, qualifies lock over a stability window, retries
//                on timeout, releases per-domain user resets in a staggered
//                order and latches a fault after repeated failures.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_PLLS            = 2,
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int REL_GAP_CYCLES      = 8
) (
    input  logic                                 refclk,
    input  logic                                 rst,
    input  logic [NUM_PLLS-1:0]                  pll_locked,
    output logic                                 pll_rst,
    output logic [NUM_PLLS-1:0]                  user_rst,
    output logic                                 all_locked,
    output logic                                 fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt,
    output logic [2:0]                           state
);

    localparam int HOLD_W  = cnt_width(RST_HOLD_CYCLES);
    localparam int STB_W   = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMR_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int GAP_W   = cnt_width(REL_GAP_CYCLES);
    localparam int IDX_W   = $clog2(NUM_PLLS) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    // Terminal counts: each counter compares against "one before the limit"
    // so the transition lands on the edge that completes the count.
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(REL_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_DONE  = IDX_W'(NUM_PLLS);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [2:0]          r_state;
    logic                r_pll_rst;
    logic [NUM_PLLS-1:0] r_user_rst;
    logic                r_all_locked;
    logic                r_fault;
    logic [RETRY_W-1:0]  r_retry;
    logic [HOLD_W-1:0]   r_hold;
    logic [STB_W-1:0]    r_stable;
    logic [TMR_W-1:0]    r_timer;
    logic [GAP_W-1:0]    r_gap;
    logic [IDX_W-1:0]    r_rel_idx;

    logic [NUM_PLLS-1:0] w_lk_sync;
    logic                w_lk;
    logic                w_acquiring;
    logic                w_qualify;
    logic                w_timeout;
    logic                w_loss;
    logic [RETRY_W-1:0]  w_retry_inc;
    logic [TMR_W-1:0]    w_timer_inc;
    logic [STB_W-1:0]    w_stable_inc;
    logic [NUM_PLLS-1:0] w_rel_mask;

    // Lock inputs are resynchronised and masked while the PLLs are in reset.
    pll_lock_sync #(
        .WIDTH    (NUM_PLLS)
    ) u_sync (
        .refclk   (refclk),
        .rst      (rst),
        .clr      (r_pll_rst),
        .async_in (pll_locked),
        .sync_out (w_lk_sync)
    );

    assign w_lk         = &w_lk_sync;
    assign w_acquiring  = (r_state == C_ST_WAIT_LOCK) || (r_state == C_ST_STABLE);
    assign w_qualify    = (r_state == C_ST_STABLE) && w_lk && (r_stable >= STB_LAST);
    // Qualification takes priority over a timeout landing on the same edge.
    assign w_timeout    = w_acquiring && (r_timer >= TMR_LAST) && !w_qualify;
    assign w_loss       = ((r_state == C_ST_RELEASE) || (r_state == C_ST_RUN)) && !w_lk;
    assign w_retry_inc  = r_retry + 1'b1;
    assign w_timer_inc  = (&r_timer)  ? r_timer  : r_timer + 1'b1;
    assign w_stable_inc = (&r_stable) ? r_stable : r_stable + 1'b1;

    // One-hot select of the user reset to release next.
    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < NUM_PLLS; i++) begin
            if (r_rel_idx == IDX_W'(i)) begin
                w_rel_mask[i] = 1'b1;
            end
        end
    end

    // Sequencer FSM with its counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state      <= C_ST_RESET_PLL;
            r_pll_rst    <= 1'b1;
            r_user_rst   <= '1;
            r_all_locked <= 1'b0;
            r_fault      <= 1'b0;
            r_retry      <= '0;
            r_hold       <= '0;
            r_stable     <= '0;
            r_timer      <= '0;
            r_gap        <= '0;
            r_rel_idx    <= '0;
        end else if (w_loss) begin
            // Runtime loss of lock: back to a fresh PLL reset, no retry charged.
            r_state      <= C_ST_RESET_PLL;
            r_pll_rst    <= 1'b1;
            r_user_rst   <= '1;
            r_all_locked <= 1'b0;
            r_hold       <= '0;
            r_stable     <= '0;
            r_timer      <= '0;
            r_gap        <= '0;
            r_rel_idx    <= '0;
        end else if (w_timeout) begin
            r_retry  <= w_retry_inc;
            r_pll_rst <= 1'b1;
            r_hold   <= '0;
            r_stable <= '0;
            r_timer  <= '0;
            if (w_retry_inc >= RETRY_MAX) begin
                r_state <= C_ST_FAULT;
                r_fault <= 1'b1;
            end else begin
                r_state <= C_ST_RESET_PLL;
            end
        end else begin
            case (r_state)
                C_ST_RESET_PLL: begin
                    r_pll_rst    <= 1'b1;
                    r_user_rst   <= '1;
                    r_all_locked <= 1'b0;
                    r_timer      <= '0;
                    if (r_hold >= HOLD_LAST) begin
                        r_hold    <= '0;
                        r_pll_rst <= 1'b0;
                        r_state   <= C_ST_WAIT_LOCK;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                C_ST_WAIT_LOCK: begin
                    r_timer <= w_timer_inc;
                    if (w_lk) begin
                        r_stable <= STB_W'(1);
                        r_state  <= C_ST_STABLE;
                    end
                end
                C_ST_STABLE: begin
                    r_timer <= w_timer_inc;
                    if (w_qualify) begin
                        r_gap     <= '0;
                        r_rel_idx <= '0;
                        r_state   <= C_ST_RELEASE;
                    end else if (w_lk) begin
                        r_stable <= w_stable_inc;
                    end else begin
                        // A dropout restarts qualification but not the timer.
                        r_stable <= '0;
                        r_state  <= C_ST_WAIT_LOCK;
                    end
                end
                C_ST_RELEASE: begin
                    if (r_rel_idx >= IDX_DONE) begin
                        r_all_locked <= 1'b1;
                        r_retry      <= '0;
                        r_state      <= C_ST_RUN;
                    end else if ((r_rel_idx == '0) || (r_gap >= GAP_LAST)) begin
                        r_user_rst <= r_user_rst & ~w_rel_mask;
                        r_rel_idx  <= r_rel_idx + 1'b1;
                        r_gap      <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                C_ST_RUN: begin
                    r_all_locked <= 1'b1;
                    r_retry      <= '0;
                end
                C_ST_FAULT: begin
                    // Terminal until rst; lock activity is ignored.
                    r_pll_rst    <= 1'b1;
                    r_user_rst   <= '1;
                    r_all_locked <= 1'b0;
                    r_fault      <= 1'b1;
                end
                default: begin
                    r_state      <= C_ST_RESET_PLL;
                    r_pll_rst    <= 1'b1;
                    r_user_rst   <= '1;
                    r_all_locked <= 1'b0;
                    r_hold       <= '0;
                    r_timer      <= '0;
                end
            endcase
        end
    end

    assign pll_rst    = r_pll_rst;
    assign user_rst   = r_user_rst;
    assign all_locked = r_all_locked;
    assign fault      = r_fault;
    assign retry_cnt  = r_retry;
    assign state      = r_state;

endmodule : pll_lock_sequencer
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_sequencer
//  Description : Self-checking bench for pll_lock_sequencer. Expected event
//                times come from an arithmetic model of the bring-up rules
//                (attempt windows, sync latency, stability window, stagger).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    localparam int NP    = 2;
    localparam int HOLD  = 16;
    localparam int STB   = 32;
    localparam int TMO   = 256;
    localparam int MAXR  = 3;
    localparam int GAP   = 8;
    localparam int NEVER = 32'h3fff_ffff;

    logic          refclk = 1'b0;
    logic          rst    = 1'b1;
    logic [NP-1:0] pll_locked = '0;
    logic          pll_rst;
    logic [NP-1:0] user_rst;
    logic          all_locked;
    logic          fault;
    logic [1:0]    retry_cnt;
    logic [2:0]    state;

    pll_lock_sequencer #(
        .NUM_PLLS            (NP),
        .RST_HOLD_CYCLES     (HOLD),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES         (MAXR),
        .REL_GAP_CYCLES      (GAP)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .user_rst   (user_rst),
        .all_locked (all_locked),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    always #10 refclk = ~refclk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc;
    int lock_rise, drop0_s, drop0_e, glitch1;

    int q_prst_fall[$], q_prst_rise[$], q_retry_rise[$];
    int q_u0_fall[$], q_u0_rise[$], q_retry_rel[$], q_u1_fall[$];
    int q_al_rise[$], q_al_fall[$], q_fault_rise[$];

    task automatic check(input string tag, input integer obs, input integer exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        if (idx >= 0 && idx < q.size()) return q[idx];
        return -1;
    endfunction

    // Lock pattern for the current cycle; sampled by the DUT on the next edge.
    task automatic drive_locks();
        pll_locked[0] = (cyc >= lock_rise) && !(cyc >= drop0_s && cyc < drop0_e);
        pll_locked[1] = (cyc >= lock_rise) && (cyc != glitch1);
    endtask

    task automatic step();
        logic          p_prst, p_al, p_flt;
        logic [NP-1:0] p_ur;
        p_prst = pll_rst; p_ur = user_rst; p_al = all_locked; p_flt = fault;
        @(posedge refclk);
        #1;
        cyc++;
        if (p_prst && !pll_rst) q_prst_fall.push_back(cyc);
        if (!p_prst && pll_rst) begin
            q_prst_rise.push_back(cyc);
            q_retry_rise.push_back(int'(retry_cnt));
        end
        if (p_ur[0] && !user_rst[0]) begin
            q_u0_fall.push_back(cyc);
            q_retry_rel.push_back(int'(retry_cnt));
        end
        if (!p_ur[0] && user_rst[0]) q_u0_rise.push_back(cyc);
        if (p_ur[1] && !user_rst[1]) q_u1_fall.push_back(cyc);
        if (!p_al && all_locked) q_al_rise.push_back(cyc);
        if (p_al && !all_locked) q_al_fall.push_back(cyc);
        if (!p_flt && fault) q_fault_rise.push_back(cyc);
        drive_locks();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Apply reset, release it and restart the cycle count at 0.
    task automatic begin_run(input int p, input int d_s, input int d_e, input int g);
        lock_rise = p; drop0_s = d_s; drop0_e = d_e; glitch1 = g;
        rst = 1'b1;
        pll_locked = '0;
        repeat (3) @(posedge refclk);
        #1;
        rst = 1'b0;
        cyc = 0;
        q_prst_fall.delete(); q_prst_rise.delete(); q_retry_rise.delete();
        q_u0_fall.delete(); q_u0_rise.delete(); q_retry_rel.delete(); q_u1_fall.delete();
        q_al_rise.delete(); q_al_fall.delete(); q_fault_rise.delete();
        drive_locks();
    endtask

    // Acquisition model: each attempt opens when pll_rst falls at f; locks seen
    // from cycle e=max(p,f) are qualified 2 (sync) + STB cycles later, unless
    // the TMO budget from f expires first. Timeout reopens HOLD cycles later.
    task automatic model_acq(input int f0, input int p, output int n_att, output int f_last,
                             output int rel, output int retry_rel, output int fault_at);
        int f, k, e, q, t;
        f = f0; k = 0; n_att = 0; f_last = f0; rel = -1; retry_rel = -1; fault_at = -1;
        for (int a = 0; a < MAXR; a++) begin
            if (rel < 0 && fault_at < 0) begin
                n_att++;
                f_last = f;
                e = (p > f) ? p : f;
                q = e + 2 + STB;
                t = f + TMO;
                if (q <= t) begin
                    rel = q + 1;
                    retry_rel = k;
                end else begin
                    k++;
                    if (k == MAXR) fault_at = t;
                    else f = t + HOLD;
                end
            end
        end
    endtask

    task automatic check_acq(input string tag, input int p);
        int n_att, f_last, rel, retry_rel, fault_at;
        model_acq(HOLD, p, n_att, f_last, rel, retry_rel, fault_at);
        check({tag, "/prst_falls"}, q_prst_fall.size(), n_att);
        check({tag, "/prst_last_fall"}, q_at(q_prst_fall, q_prst_fall.size() - 1), f_last);
        if (rel >= 0) begin
            check({tag, "/u0_fall"}, q_at(q_u0_fall, 0), rel);
            check({tag, "/u1_fall"}, q_at(q_u1_fall, 0), rel + GAP);
            check({tag, "/al_rise"}, q_at(q_al_rise, 0), rel + GAP + 1);
            check({tag, "/retry_at_rel"}, q_at(q_retry_rel, 0), retry_rel);
            check({tag, "/retry_run"}, retry_cnt, 0);
            check({tag, "/fault"}, fault, 0);
        end else begin
            check({tag, "/fault_rise"}, q_at(q_fault_rise, 0), fault_at);
            check({tag, "/retry_fault"}, retry_cnt, MAXR);
            check({tag, "/prst_fault"}, pll_rst, 1);
            check({tag, "/ursts_fault"}, user_rst, 3);
            check({tag, "/u0_never"}, q_u0_fall.size(), 0);
            check({tag, "/state_fault"}, state, C_ST_FAULT);
        end
    endtask

    initial begin
        int p, d, dur, n_att, f_last, rel, retry_rel, fault_at;

        // Nominal bring-up with reset-state check at cycle 0.
        begin_run(0, NEVER, NEVER, -1);
        check("rst/pll_rst", pll_rst, 1);
        check("rst/user_rst", user_rst, 3);
        check("rst/all_locked", all_locked, 0);
        check("rst/fault", fault, 0);
        check("rst/retry", retry_cnt, 0);
        check("rst/state", state, C_ST_RESET_PLL);
        run(80);
        check("nom/prst_fall", q_at(q_prst_fall, 0), 16);
        check("nom/u0_fall", q_at(q_u0_fall, 0), 51);
        check("nom/u1_fall", q_at(q_u1_fall, 0), 59);
        check("nom/al_rise", q_at(q_al_rise, 0), 60);
        check("nom/state", state, C_ST_RUN);
        check_acq("nom", 0);

        // Glitch on lock[1] when the stable count is 20.
        begin_run(0, NEVER, NEVER, 36);
        run(120);
        check("glitch/u0_fall", q_at(q_u0_fall, 0), 72);
        check("glitch/retry", q_at(q_retry_rel, 0), 0);
        check("glitch/prst_falls", q_prst_fall.size(), 1);

        // Timeout and qualification on the same edge: qualification wins.
        begin_run(238, NEVER, NEVER, -1);
        run(320);
        check("same/u0_fall", q_at(q_u0_fall, 0), 273);
        check("same/retry", q_at(q_retry_rel, 0), 0);
        check("same/no_retry_pulse", q_prst_rise.size(), 0);
        // One cycle later the timeout wins.
        begin_run(239, NEVER, NEVER, -1);
        run(400);
        check_acq("late1", 239);
        check("late1/retry_pulse", q_at(q_retry_rise, 0), 1);

        // Timeout to fault; locks arrive after the fault and are ignored.
        begin_run(900, NEVER, NEVER, -1);
        run(1100);
        check("tmo/rise0", q_at(q_prst_rise, 0), 272);
        check("tmo/fall1", q_at(q_prst_fall, 1), 288);
        check("tmo/rise1", q_at(q_prst_rise, 1), 544);
        check("tmo/fall2", q_at(q_prst_fall, 2), 560);
        check("tmo/retry1", q_at(q_retry_rise, 0), 1);
        check("tmo/retry2", q_at(q_retry_rise, 1), 2);
        check("tmo/fault_rise", q_at(q_fault_rise, 0), 816);
        check_acq("tmo", 900);

        // Runtime loss of lock[0], randomized drop time and duration.
        for (int tr = 0; tr < 3; tr++) begin
            d   = $urandom_range(65, 120);
            dur = $urandom_range(1, 60);
            begin_run(0, d, d + dur, -1);
            run(d + 150);
            model_acq(d + 19, d + dur, n_att, f_last, rel, retry_rel, fault_at);
            check("loss/al_first", q_at(q_al_rise, 0), 60);
            check("loss/u0_rise", q_at(q_u0_rise, 0), d + 3);
            check("loss/al_fall", q_at(q_al_fall, 0), d + 3);
            check("loss/prst_rise", q_at(q_prst_rise, 0), d + 3);
            check("loss/prst_fall", q_at(q_prst_fall, 1), d + 19);
            check("loss/prst_falls", q_prst_fall.size(), 1 + n_att);
            check("loss/u0_refall", q_at(q_u0_fall, 1), rel);
            check("loss/al_rerise", q_at(q_al_rise, 1), rel + GAP + 1);
            check("loss/retry", retry_cnt, 0);
            check("loss/retry_rel", q_at(q_retry_rel, 1), 0);
        end

        // Reset during RELEASE, then a full nominal sequence.
        begin_run(0, NEVER, NEVER, -1);
        run(55);
        check("midrst/ursts", user_rst, 2);
        rst = 1'b1;
        step();
        check("midrst/pll_rst", pll_rst, 1);
        check("midrst/user_rst", user_rst, 3);
        check("midrst/all_locked", all_locked, 0);
        check("midrst/fault", fault, 0);
        check("midrst/retry", retry_cnt, 0);
        check("midrst/state", state, C_ST_RESET_PLL);
        begin_run(0, NEVER, NEVER, -1);
        run(80);
        check("midrst/u0_fall", q_at(q_u0_fall, 0), 51);
        check("midrst/al_rise", q_at(q_al_rise, 0), 60);

        // Randomized lock arrival times against the acquisition model.
        for (int tr = 0; tr < 6; tr++) begin
            p = $urandom_range(0, 1000);
            begin_run(p, NEVER, NEVER, -1);
            run(1100);
            check_acq("rnd", p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_pll_lock_sequencer
`default_nettype wire

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Parametrised PLL bring-up and lock supervisor for the accelerator's clock subsystem, the next generation of our single-PLL wrapper. It drives the reset of up to `NUM_PLLS` PLL instances and samples their asynchronous `locked` outputs. It qualifies lock with a stability window, retries acquisition with a timeout, and releases per-domain user resets in a fixed staggered order. Loss of lock at runtime re-enters the reset sequence; repeated acquisition failure latches a fault.

## Interface
Parameters:
- `NUM_PLLS`, 2: number of supervised PLLs, 1..8.
- `RST_HOLD_CYCLES`, 16: PLL reset pulse width in `refclk` cycles, ≥2.
- `LOCK_STABLE_CYCLES`, 1024: consecutive all-locked samples required to qualify lock.
- `LOCK_TIMEOUT_CYCLES`, 65536: acquisition budget per attempt; must exceed `LOCK_STABLE_CYCLES`.
- `MAX_RETRIES`, 3: timeouts tolerated before fault, ≥1.
- `REL_GAP_CYCLES`, 8: spacing between successive user-reset releases, ≥1.

Ports:
- `refclk` in 1: sole clock; the 50 MHz board reference.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in `NUM_PLLS`: raw PLL lock outputs, asynchronous to `refclk`.
- `pll_rst` out 1: reset to all PLLs, active-high.
- `user_rst` out `NUM_PLLS`: per-output-domain reset, active-high.
- `all_locked` out 1: high only in RUN.
- `fault` out 1: sticky acquisition failure.
- `retry_cnt` out `$clog2(MAX_RETRIES+1)`: timeouts in the current bring-up.
- `state` out 3: FSM state encoding, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchroniser. `lk` is the AND of the synchronised bits.
- The FSM states are RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
- **RESET_PLL**
  - `pll_rst`=1 and all `user_rst`=1.
  - The hold counter runs for `RST_HOLD_CYCLES` cycles, then the FSM goes to WAIT_LOCK.
  - Entry to RESET_PLL clears the acquisition timer.
- **WAIT_LOCK**
  - `pll_rst`=0 and the acquisition timer runs.
  - `lk`=1 moves the FSM to STABLE, with the stable counter set to 1.
- **STABLE**
  - The timer keeps running.
  - `lk`=1 increments the stable counter. When it reaches `LOCK_STABLE_CYCLES` the FSM goes to RELEASE.
  - `lk`=0 returns the FSM to WAIT_LOCK; the timer is not cleared.
- **Timeout**
  - Applies in WAIT_LOCK or STABLE, when the timer reaches `LOCK_TIMEOUT_CYCLES`.
  - `retry_cnt` increments.
  - If the new value equals `MAX_RETRIES`, the FSM goes to FAULT; otherwise it goes to RESET_PLL.
  - If timeout and qualification occur in the same cycle, qualification wins.
- **RELEASE**
  - `user_rst[0]` deasserts first. Each `user_rst[i]` deasserts `REL_GAP_CYCLES` after `user_rst[i-1]`.
  - After `user_rst[NUM_PLLS-1]` deasserts, the FSM goes to RUN.
- **RUN**
  - `all_locked`=1 and `retry_cnt` clears to 0.
- **Loss of lock in RELEASE or RUN** (`lk`=0)
  - All `user_rst` reassert, `all_locked`=0, and the FSM goes to RESET_PLL.
  - Loss of lock does not count as a retry.
- **FAULT**
  - `pll_rst`=1, all `user_rst`=1, `fault`=1.
  - The state is terminal until `rst`; `pll_locked` activity is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `pll_rst`=1, `user_rst`=all 1s.
  - `all_locked`=0, `fault`=0, `retry_cnt`=0.
  - `state`=RESET_PLL; all counters 0.
- `rst` mid-operation, in any state: outputs take their reset values on the next edge and the sequence restarts.
- `pll_rst` stays high for exactly `RST_HOLD_CYCLES` cycles after `rst` deasserts.
- `pll_locked` to `lk` latency is 2 cycles.
- Minimum `pll_rst` fall to `user_rst[0]` fall is 2 + `LOCK_STABLE_CYCLES` + 1 cycles.
- `all_locked` rises 1 cycle after `user_rst[NUM_PLLS-1]` falls.
- Loss of lock reaches the outputs within 3 cycles of the `pll_locked` fall: 2 cycles for sync plus 1 register stage.

## Structure
- Package `pll_seq_pkg` holds:
  - the FSM state enum and its 3-bit encoding, shared with the debug register map;
  - the counter-width function.
- Sub-module `pll_lock_sync` is a `NUM_PLLS`-wide 2-flop synchroniser carrying synchroniser timing attributes.
- Counter widths:
  - hold, stable and timer counters are sized `$clog2` of their parameter plus 1, and saturate;
  - the release index is `$clog2(NUM_PLLS)+1` bits.

## Test plan
All scenarios use `NUM_PLLS`=2, `RST_HOLD_CYCLES`=16, `LOCK_STABLE_CYCLES`=32, `LOCK_TIMEOUT_CYCLES`=256, `MAX_RETRIES`=3, `REL_GAP_CYCLES`=8.
- **Nominal bring-up:** both locks high from cycle 0 → `pll_rst` falls at cycle 16; `user_rst[0]` falls at cycle 51; `user_rst[1]` falls at 59; `all_locked` rises at 60.
- **Glitch in STABLE:** `pll_locked[1]` low for 1 cycle at stable count 20 → qualification restarts; `user_rst[0]` falls ≥ 21 cycles later than nominal; `retry_cnt` stays 0.
- **Timeout to fault:** locks never assert → 3 `pll_rst` pulses, each 16 cycles; `retry_cnt` goes 1 then 2; after the third timeout `fault`=1 and `pll_rst`=1; later lock assertion has no effect.
- **Runtime loss:** in RUN, drop `pll_locked[0]` → within 3 cycles both `user_rst`=1 and `all_locked`=0; a 16-cycle `pll_rst` pulse follows; re-acquisition reaches RUN with `retry_cnt`=0.
- **Reset mid-RELEASE:** assert `rst` when `user_rst`=2'b10 → next cycle all outputs take reset values; a full nominal sequence follows.
- **Same-cycle boundary:** timeout and qualification in the same cycle → FSM enters RELEASE and `retry_cnt` does not increment.
